// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
//   Data SRAM stage that sits after the execute/register2 path. Stores are
//   written into the array at the clock edge. Load data is registered, so it
//   appears one clock after the request. This lines it up with register2 for
//   write-back. After reset, an internal clear sweep can zero the whole array.
//
// Parameters
//   D_BITS          data word width
//   A_BITS          word address width (depth = 2**A_BITS words)
//   CLEAR_ON_RESET  1: run the zeroing sweep after reset
//                   0: start in READY (array contents undefined)
//
// Ports
//   clk       in   single clock, rising edge
//   nrst      in   asynchronous reset, ACTIVE-HIGH despite the name
//   read      in   load request
//   write     in   store request
//   address   in   word address of the load/store
//   data_in   in   store data
//   data_out  out  registered load data; held until the next accepted load
//   busy      out  1 while the clear sweep runs; requests are ignored then
//   err       out  1-cycle pulse after an ignored request or a read&write
//   rd_count  out  accepted loads, saturating (zero when stats are disabled)
//   wr_count  out  accepted stores, saturating (zero when stats are disabled)
//
// Build option
//   DMEM_STATS_EN  define this macro to implement rd_count/wr_count.
//                  Without it both outputs are constant 16'h0000.
// -----------------------------------------------------------------------------
module data_mem_unit #(
   parameter int D_BITS         = 32,
   parameter int A_BITS         = 10,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              read,
   input  logic              write,
   input  logic [A_BITS-1:0] address,
   input  logic [D_BITS-1:0] data_in,
   output logic [D_BITS-1:0] data_out,
   output logic              busy,
   output logic              err,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int DEPTH = 1 << A_BITS;

   // FSM encoding. The two unused codes fall back to READY.
   localparam logic [1:0] CLEAR = 2'b01;
   localparam logic [1:0] READY = 2'b10;

   localparam logic [1:0]        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
   localparam logic              RESET_BUSY  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
   localparam logic [A_BITS-1:0] LAST_ADDR   = {A_BITS{1'b1}};

   logic [D_BITS-1:0] mem [0:DEPTH-1];

   logic [1:0]        state_r;
   logic              busy_r;
   logic              err_r;
   logic [A_BITS-1:0] clr_addr_r;
   logic [D_BITS-1:0] data_out_r;

   logic              mem_we_s;
   logic [A_BITS-1:0] mem_addr_s;
   logic [D_BITS-1:0] mem_wdata_s;

   // Array write-port select: the clear sweep owns the port in CLEAR, stores own it in READY.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = address;
      mem_wdata_s = data_in;
      case (state_r)
         CLEAR: begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_addr_r;
            mem_wdata_s = {D_BITS{1'b0}};
         end
         READY: begin
            mem_we_s = write;
         end
         default: begin
            mem_we_s = 1'b0;
         end
      endcase
      // Nothing may reach the array while reset is held.
      mem_we_s = mem_we_s & ~nrst;
   end

   // Storage array, with no reset so it maps onto SRAM.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem[mem_addr_s] <= mem_wdata_s;
      end
   end

   // Control FSM, clear-address counter, registered load data and error pulse.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_r    <= RESET_STATE;
         busy_r     <= RESET_BUSY;
         err_r      <= 1'b0;
         clr_addr_r <= {A_BITS{1'b0}};
         data_out_r <= {D_BITS{1'b0}};
      end else begin
         case (state_r)
            CLEAR: begin
               clr_addr_r <= clr_addr_r + A_BITS'(1'b1);
               err_r      <= read | write;
               // After the last word is written, busy drops on this same edge.
               if (clr_addr_r == LAST_ADDR) begin
                  state_r <= READY;
                  busy_r  <= 1'b0;
               end
            end
            READY: begin
               err_r <= read & write;
               if (read && write) begin
                  // Write-first: a simultaneous load returns the store data.
                  data_out_r <= data_in;
               end else if (read) begin
                  data_out_r <= mem[address];
               end
            end
            default: begin
               state_r <= READY;
               busy_r  <= 1'b0;
               err_r   <= read | write;
            end
         endcase
      end
   end

`ifdef DMEM_STATS_EN
   logic [15:0] rd_count_r;
   logic [15:0] wr_count_r;

   // Saturating counters of accepted accesses. A read&write bumps both.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         rd_count_r <= 16'h0000;
         wr_count_r <= 16'h0000;
      end else if (state_r == READY) begin
         if (read && (rd_count_r != 16'hFFFF)) begin
            rd_count_r <= rd_count_r + 16'h0001;
         end
         if (write && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'h0001;
         end
      end
   end

   assign rd_count = rd_count_r;
   assign wr_count = wr_count_r;
`else
   assign rd_count = 16'h0000;
   assign wr_count = 16'h0000;
`endif

   assign data_out = data_out_r;
   assign busy     = busy_r;
   assign err      = err_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_unit
//   Directed-vector bench for data_mem_unit with A_BITS=4 and CLEAR_ON_RESET=1.
//   Inputs are driven 1 ns after a rising edge. Outputs are sampled at that
//   same point, so each sample shows the effect of the edge just passed.
// -----------------------------------------------------------------------------
module tb_data_mem_unit;

   localparam int D_BITS = 32;
   localparam int A_BITS = 4;

   logic              clk = 1'b0;
   logic              nrst = 1'b1;
   logic              read = 1'b0;
   logic              write = 1'b0;
   logic [A_BITS-1:0] address = 4'h0;
   logic [D_BITS-1:0] data_in = 32'h0000_0000;
   logic [D_BITS-1:0] data_out;
   logic              busy;
   logic              err;
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;

   int vectors = 0;
   int miscompares = 0;

   data_mem_unit #(
      .D_BITS         (D_BITS),
      .A_BITS         (A_BITS),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .read     (read),
      .write    (write),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .err      (err),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      read  = 1'b0;
      write = 1'b0;
   endtask

   // Count the clocks until busy drops, starting from n0 clocks already spent.
   task automatic wait_sweep(input string tag, input int n0);
      int n;
      n = n0;
      while (busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'd16);
   endtask

   task automatic access(input logic r, input logic w, input logic [A_BITS-1:0] a,
                         input logic [D_BITS-1:0] d);
      read    = r;
      write   = w;
      address = a;
      data_in = d;
      tick();
      idle();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state.
      tick();
      tick();
      chk("rst_data_out", data_out, 32'h0000_0000);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
      chk("rst_wr_count", {16'd0, wr_count}, 32'd0);

      // 1: the sweep lasts exactly 16 clocks, then every word reads back zero.
      nrst = 1'b0;
      wait_sweep("clear_len", 0);
      for (int a = 0; a < 16; a++) begin
         access(1'b1, 1'b0, a[A_BITS-1:0], 32'h0);
         chk("clear_read", data_out, 32'h0000_0000);
      end

      // 2: a store leaves data_out alone; the load returns it and data_out holds.
      access(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF);
      chk("store_no_dout", data_out, 32'h0000_0000);
      chk("store_no_err", {31'd0, err}, 32'd0);
      access(1'b1, 1'b0, 4'd3, 32'h0);
      chk("load_a3", data_out, 32'hDEAD_BEEF);
      address = 4'd7;
      tick();
      tick();
      chk("load_hold", data_out, 32'hDEAD_BEEF);

      // 3: read&write is write-first and raises a one-cycle err.
      access(1'b1, 1'b1, 4'd5, 32'h1234_5678);
      chk("rw_dout", data_out, 32'h1234_5678);
      chk("rw_err", {31'd0, err}, 32'd1);
      tick();
      chk("rw_err_drop", {31'd0, err}, 32'd0);
      access(1'b1, 1'b0, 4'd3, 32'h0);
      chk("reload_a3", data_out, 32'hDEAD_BEEF);
      access(1'b1, 1'b0, 4'd5, 32'h0);
      chk("reload_a5", data_out, 32'h1234_5678);

      // A load immediately after a store to the same address sees the new value.
      access(1'b0, 1'b1, 4'd9, 32'hAAAA_5555);
      access(1'b1, 1'b0, 4'd9, 32'h0);
      chk("b2b_a9", data_out, 32'hAAAA_5555);

      // 5a: asynchronous reset after a load clears data_out and raises busy at once.
      nrst = 1'b1;
      #1;
      chk("async_dout", data_out, 32'h0000_0000);
      chk("async_busy", {31'd0, busy}, 32'd1);
      tick();
      nrst = 1'b0;

      // 4: a store during the sweep is ignored and flagged.
      access(1'b0, 1'b1, 4'd2, 32'hFFFF_FFFF);
      chk("busy_err", {31'd0, err}, 32'd1);
      tick();
      chk("busy_err_drop", {31'd0, err}, 32'd0);
      wait_sweep("clear_len2", 2);
      access(1'b0, 1'b1, 4'd4, 32'h0000_0001);
      access(1'b1, 1'b0, 4'd4, 32'h0);
      chk("load_a4", data_out, 32'h0000_0001);
      access(1'b1, 1'b0, 4'd2, 32'h0);
      chk("ignored_a2", data_out, 32'h0000_0000);
      access(1'b1, 1'b0, 4'd9, 32'h0);
      chk("cleared_a9", data_out, 32'h0000_0000);

      // 5b: reset in the middle of a sweep restarts it at full length.
      nrst = 1'b1;
      tick();
      nrst = 1'b0;
      repeat (5) tick();
      nrst = 1'b1;
      #1;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      tick();
      nrst = 1'b0;
      wait_sweep("clear_restart", 0);

`ifdef DMEM_STATS_EN
      // 6: counters. Requests ignored during the sweep do not count.
      nrst = 1'b1;
      tick();
      nrst = 1'b0;
      access(1'b1, 1'b1, 4'd1, 32'h5);
      wait_sweep("clear_len3", 1);
      chk("cnt_busy_rd", {16'd0, rd_count}, 32'd0);
      access(1'b0, 1'b1, 4'd0, 32'h10);
      access(1'b0, 1'b1, 4'd1, 32'h11);
      access(1'b0, 1'b1, 4'd2, 32'h12);
      access(1'b1, 1'b0, 4'd0, 32'h0);
      access(1'b1, 1'b0, 4'd1, 32'h0);
      access(1'b1, 1'b1, 4'd6, 32'h66);
      chk("cnt_wr4", {16'd0, wr_count}, 32'd4);
      chk("cnt_rd3", {16'd0, rd_count}, 32'd3);
      read = 1'b1;
      repeat (65531) tick();
      chk("cnt_rd_fffe", {16'd0, rd_count}, 32'h0000_FFFE);
      repeat (3) tick();
      idle();
      chk("cnt_rd_sat", {16'd0, rd_count}, 32'h0000_FFFF);
      chk("cnt_wr_keep", {16'd0, wr_count}, 32'd4);
`else
      // 6: with stats disabled, both counters stay zero after accesses.
      access(1'b0, 1'b1, 4'd0, 32'h10);
      access(1'b1, 1'b0, 4'd0, 32'h0);
      chk("load_a0", data_out, 32'h0000_0010);
      chk("nostat_rd", {16'd0, rd_count}, 32'd0);
      chk("nostat_wr", {16'd0, wr_count}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
